// File: rtl/cla_seq_add_ctrl.sv
// Serialised WIDTH-bit add/subtract: one 4-bit carry-lookahead slice reused per nibble,
// LSB nibble first, with the carry held in a register between nibbles.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       c3,
    output logic       co
);
    logic [3:0] g, p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        s    = p ^ c[3:0];
        c3   = c[3];
        co   = c[4];
    end
endmodule

module cla_seq_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, nxt;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [3:0]       s_nib;
    logic             c3_nib, co_nib;
    logic             last;

    assign last = (idx == IW'(NIB - 1));

    cla4_slice u_slice (
        .a  (a_reg[{idx, 2'b00} +: 4]),
        .b  (b_reg[{idx, 2'b00} +: 4]),
        .ci (carry),
        .s  (s_nib),
        .c3 (c3_nib),
        .co (co_nib)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (in_valid) nxt = RUN;
            RUN:     if (last) nxt = DONE;
            DONE:    if (out_valid && out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    // Subtract is a + ~b + 1, so the inversion and the forced carry happen at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // out_valid rises one edge after DONE is entered and drops on the handshake edge.
            out_valid <= (state == DONE) && !(out_valid && out_ready);
            case (state)
                IDLE: if (in_valid) begin
                    a_reg <= a;
                    b_reg <= sub ? ~b : b;
                    carry <= sub | cin;
                    idx   <= '0;
                    sum   <= '0;
                    cout  <= 1'b0;
                    ovf   <= 1'b0;
                end
                RUN: begin
                    sum[{idx, 2'b00} +: 4] <= s_nib;
                    carry <= co_nib;
                    if (last) begin
                        cout <= co_nib;
                        ovf  <= c3_nib ^ co_nib;
                        idx  <= '0;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
